// File: rtl/lrwait_pkg.sv
// Shared definitions for the LRWait tail controller slice.
//   amo_op_t   : AMO opcode encoding carried on in_qamo_i / bank_qamo_o
//   su_state_t : occupancy of the single SuccUpdate response register
//   slot_t     : layout of one reservation slot at the default widths
//   DefaultMetaWidth : requester metadata width, built from its fields
package lrwait_pkg;

  // Requester metadata fields, packed {ini_addr, meta_id, core_id, tile_id, lrwait}.
  localparam int unsigned IniAddrWidth    = 1;
  localparam int unsigned MetaIdWidth     = 4;
  localparam int unsigned CoreIdWidth     = 4;
  localparam int unsigned TileIdWidth     = 2;
  localparam int unsigned LrwaitFlagWidth = 1;
  localparam int unsigned DefaultMetaWidth =
    IniAddrWidth + MetaIdWidth + CoreIdWidth + TileIdWidth + LrwaitFlagWidth;

  localparam int unsigned DefaultAddrWidth = 32;
  localparam int unsigned DefaultDataWidth = 32;

  typedef enum logic [3:0] {
    AMO_NONE = 4'h0,
    AMO_SWAP = 4'h1,
    AMO_ADD  = 4'h2,
    AMO_AND  = 4'h3,
    AMO_OR   = 4'h4,
    AMO_XOR  = 4'h5,
    AMO_MAX  = 4'h6,
    AMO_MAXU = 4'h7,
    AMO_MIN  = 4'h8,
    AMO_MINU = 4'h9,
    AMO_LR   = 4'hA,
    AMO_SC   = 4'hB
  } amo_op_t;

  typedef enum logic {
    SU_EMPTY   = 1'b0,
    SU_PENDING = 1'b1
  } su_state_t;

  // Slot addresses hold the word address only (byte offset dropped).
  typedef struct packed {
    logic                          valid;
    logic [DefaultAddrWidth-3:0]   addr;
    logic [DefaultMetaWidth-1:0]   tail_meta;
  } slot_t;

endpackage

// File: rtl/lrwait_slot_table.sv
// Reservation slot storage for the LRWait tail controller.
//   lookup_addr_i  : word address of the current request
//   match_o        : a valid slot holds lookup_addr_i
//   match_tail_o   : tail metadata of the matching slot
//   free_avail_o   : at least one slot is invalid
//   alloc_i        : allocate lowest free slot with {lookup_addr_i, alloc_tail_i}
//   update_i       : overwrite the matching slot's tail with update_tail_i
//   release_i      : invalidate the matching slot
module lrwait_slot_table #(
  parameter int unsigned NumSlots  = 4,
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned MetaWidth = 12
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [AddrWidth-3:0] lookup_addr_i,
  output logic                 match_o,
  output logic [MetaWidth-1:0] match_tail_o,
  output logic                 free_avail_o,
  input  logic                 alloc_i,
  input  logic [MetaWidth-1:0] alloc_tail_i,
  input  logic                 update_i,
  input  logic [MetaWidth-1:0] update_tail_i,
  input  logic                 release_i
);

  localparam int unsigned IdxWidth = (NumSlots > 1) ? $clog2(NumSlots) : 1;

  logic [NumSlots-1:0]  valid_q;
  logic [AddrWidth-3:0] addr_q [NumSlots];
  logic [MetaWidth-1:0] tail_q [NumSlots];

  logic [NumSlots-1:0]  hit;
  logic [IdxWidth-1:0]  match_idx;
  logic [IdxWidth-1:0]  free_idx;

  // Descending scans so the lowest index is the last one written and wins.
  always_comb begin
    hit          = '0;
    match_idx    = '0;
    match_tail_o = '0;
    free_idx     = '0;
    for (int unsigned i = 0; i < NumSlots; i++) begin
      hit[i] = valid_q[i] && (addr_q[i] == lookup_addr_i);
    end
    for (int unsigned i = NumSlots; i > 0; i--) begin
      if (hit[i-1]) begin
        match_idx    = IdxWidth'(i - 1);
        match_tail_o = tail_q[i-1];
      end
      if (!valid_q[i-1]) begin
        free_idx = IdxWidth'(i - 1);
      end
    end
  end

  assign match_o      = |hit;
  assign free_avail_o = ~&valid_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
      for (int unsigned i = 0; i < NumSlots; i++) begin
        addr_q[i] <= '0;
        tail_q[i] <= '0;
      end
    end else begin
      if (alloc_i && free_avail_o && !match_o) begin
        valid_q[free_idx] <= 1'b1;
        addr_q[free_idx]  <= lookup_addr_i;
        tail_q[free_idx]  <= alloc_tail_i;
      end
      if (update_i && match_o) begin
        tail_q[match_idx] <= update_tail_i;
      end
      if (release_i && match_o) begin
        valid_q[match_idx] <= 1'b0;
      end
    end
  end

  a_single_match: assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(hit));

endmodule

// File: rtl/lrwait_tail_ctrl.sv
// Bank-side LRWait/MCS queue tail controller, placed in front of one TCDM bank.
//   in_q*   : request from the tile interconnect (in_qlrwait_i marks a WakeUp)
//   bank_q* : request forwarded to the bank
//   bank_p* : response from the bank
//   out_p*  : response to the interconnect; out_plrwait_o marks a SuccUpdate
// First LR to an address goes to the bank and opens a slot; later LRs to the
// same word become SuccUpdates to the previous tail. WakeUps become bank LRs on
// behalf of the successor. An SC from the tail closes the slot.
module lrwait_tail_ctrl
  import lrwait_pkg::*;
#(
  parameter int unsigned NumSlots  = 4,
  parameter int unsigned AddrWidth = DefaultAddrWidth,
  parameter int unsigned DataWidth = DefaultDataWidth,
  parameter int unsigned MetaWidth = DefaultMetaWidth
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [AddrWidth-1:0]   in_qaddr_i,
  input  logic                   in_qwrite_i,
  input  logic [3:0]             in_qamo_i,
  input  logic [DataWidth-1:0]   in_qdata_i,
  input  logic [DataWidth/8-1:0] in_qstrb_i,
  input  logic [MetaWidth-1:0]   in_qmeta_i,
  input  logic                   in_qlrwait_i,
  input  logic                   in_qvalid_i,
  output logic                   in_qready_o,
  output logic [AddrWidth-1:0]   bank_qaddr_o,
  output logic                   bank_qwrite_o,
  output logic [3:0]             bank_qamo_o,
  output logic [DataWidth-1:0]   bank_qdata_o,
  output logic [DataWidth/8-1:0] bank_qstrb_o,
  output logic [MetaWidth-1:0]   bank_qmeta_o,
  output logic                   bank_qvalid_o,
  input  logic                   bank_qready_i,
  input  logic [DataWidth-1:0]   bank_pdata_i,
  input  logic [MetaWidth-1:0]   bank_pmeta_i,
  input  logic                   bank_pvalid_i,
  output logic                   bank_pready_o,
  output logic [DataWidth-1:0]   out_pdata_o,
  output logic [MetaWidth-1:0]   out_pmeta_o,
  output logic                   out_plrwait_o,
  output logic                   out_pvalid_o,
  input  logic                   out_pready_i
);

  amo_op_t amo;
  logic    is_lr, is_sc, is_wakeup;

  assign amo       = amo_op_t'(in_qamo_i);
  assign is_wakeup = in_qlrwait_i && (amo == AMO_LR);
  assign is_lr     = !in_qlrwait_i && (amo == AMO_LR);
  assign is_sc     = (amo == AMO_SC);

  logic                 match, free_avail;
  logic [MetaWidth-1:0] match_tail;
  logic                 alloc, su_push, release_slot;

  su_state_t            su_state_q;
  logic [MetaWidth-1:0] su_dest_q, su_data_q;
  logic                 su_pending, su_room;

  assign su_pending = (su_state_q == SU_PENDING);
  // Register can take a new SuccUpdate in the same cycle it is being drained.
  assign su_room    = !su_pending || out_pready_i;

  lrwait_slot_table #(
    .NumSlots (NumSlots),
    .AddrWidth(AddrWidth),
    .MetaWidth(MetaWidth)
  ) i_slot_table (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .lookup_addr_i(in_qaddr_i[AddrWidth-1:2]),
    .match_o      (match),
    .match_tail_o (match_tail),
    .free_avail_o (free_avail),
    .alloc_i      (alloc),
    .alloc_tail_i (in_qmeta_i),
    .update_i     (su_push),
    .update_tail_i(in_qmeta_i),
    .release_i    (release_slot)
  );

  assign bank_qaddr_o  = in_qaddr_i;
  assign bank_qwrite_o = in_qwrite_i;
  assign bank_qamo_o   = in_qamo_i;
  assign bank_qstrb_o  = in_qstrb_i;

  always_comb begin
    bank_qvalid_o = in_qvalid_i;
    in_qready_o   = bank_qready_i;
    bank_qmeta_o  = in_qmeta_i;
    bank_qdata_o  = in_qdata_i;
    alloc         = 1'b0;
    su_push       = 1'b0;
    release_slot  = 1'b0;
    if (is_wakeup) begin
      // Issue the LR on behalf of the successor carried in the data field.
      bank_qmeta_o = in_qdata_i[MetaWidth-1:0];
      bank_qdata_o = '0;
    end else if (is_lr) begin
      if (match) begin
        bank_qvalid_o = 1'b0;
        in_qready_o   = su_room;
        su_push       = in_qvalid_i && su_room;
      end else if (!free_avail) begin
        bank_qvalid_o = 1'b0;
        in_qready_o   = 1'b0;
      end else begin
        alloc = in_qvalid_i && bank_qready_i;
      end
    end else if (is_sc) begin
      release_slot = in_qvalid_i && bank_qready_i && match && (match_tail == in_qmeta_i);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      su_state_q <= SU_EMPTY;
      su_dest_q  <= '0;
      su_data_q  <= '0;
    end else if (su_push) begin
      su_state_q <= SU_PENDING;
      su_dest_q  <= match_tail;
      su_data_q  <= in_qmeta_i;
    end else if (su_pending && out_pready_i) begin
      su_state_q <= SU_EMPTY;
    end
  end

  assign out_pvalid_o  = su_pending || bank_pvalid_i;
  assign out_pdata_o   = su_pending ? DataWidth'(su_data_q) : bank_pdata_i;
  assign out_pmeta_o   = su_pending ? su_dest_q : bank_pmeta_i;
  assign out_plrwait_o = su_pending;
  assign bank_pready_o = su_pending ? 1'b0 : out_pready_i;

  a_wakeup_has_slot: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (in_qvalid_i && is_wakeup) |-> match);

endmodule

// File: tb/tb_lrwait_tail_ctrl.sv
module tb_lrwait_tail_ctrl;
  import lrwait_pkg::*;

  localparam logic [3:0]  LR     = 4'hA;
  localparam logic [3:0]  SC     = 4'hB;
  localparam logic [31:0] SCDATA = 32'h0000_5C5C;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [31:0] in_qaddr_i = '0;
  logic        in_qwrite_i = 1'b0;
  logic [3:0]  in_qamo_i = '0;
  logic [31:0] in_qdata_i = '0;
  logic [3:0]  in_qstrb_i = 4'hF;
  logic [11:0] in_qmeta_i = '0;
  logic        in_qlrwait_i = 1'b0;
  logic        in_qvalid_i = 1'b0;
  logic        in_qready_o;
  logic [31:0] bank_qaddr_o;
  logic        bank_qwrite_o;
  logic [3:0]  bank_qamo_o;
  logic [31:0] bank_qdata_o;
  logic [3:0]  bank_qstrb_o;
  logic [11:0] bank_qmeta_o;
  logic        bank_qvalid_o;
  logic        bank_qready_i = 1'b1;
  logic [31:0] bank_pdata_i;
  logic [11:0] bank_pmeta_i;
  logic        bank_pvalid_i;
  logic        bank_pready_o;
  logic [31:0] out_pdata_o;
  logic [11:0] out_pmeta_o;
  logic        out_plrwait_o;
  logic        out_pvalid_o;
  logic        out_pready_i = 1'b1;

  lrwait_tail_ctrl #(
    .NumSlots (4),
    .AddrWidth(32),
    .DataWidth(32),
    .MetaWidth(12)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .in_qaddr_i(in_qaddr_i), .in_qwrite_i(in_qwrite_i), .in_qamo_i(in_qamo_i),
    .in_qdata_i(in_qdata_i), .in_qstrb_i(in_qstrb_i), .in_qmeta_i(in_qmeta_i),
    .in_qlrwait_i(in_qlrwait_i), .in_qvalid_i(in_qvalid_i), .in_qready_o(in_qready_o),
    .bank_qaddr_o(bank_qaddr_o), .bank_qwrite_o(bank_qwrite_o), .bank_qamo_o(bank_qamo_o),
    .bank_qdata_o(bank_qdata_o), .bank_qstrb_o(bank_qstrb_o), .bank_qmeta_o(bank_qmeta_o),
    .bank_qvalid_o(bank_qvalid_o), .bank_qready_i(bank_qready_i),
    .bank_pdata_i(bank_pdata_i), .bank_pmeta_i(bank_pmeta_i), .bank_pvalid_i(bank_pvalid_i),
    .bank_pready_o(bank_pready_o),
    .out_pdata_o(out_pdata_o), .out_pmeta_o(out_pmeta_o), .out_plrwait_o(out_plrwait_o),
    .out_pvalid_o(out_pvalid_o), .out_pready_i(out_pready_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [31:0] addr; logic write; logic [3:0] amo;
    logic [31:0] data; logic [3:0] strb; logic [11:0] meta;
  } breq_t;
  typedef struct packed { logic [31:0] data; logic [11:0] meta; logic lrwait; } oresp_t;
  typedef struct packed { logic [31:0] data; logic [11:0] meta; } bresp_t;

  breq_t  exp_bank_q[$];
  oresp_t exp_su_q[$];
  oresp_t exp_rsp_q[$];
  bresp_t bank_rsp_q[$];
  logic   bank_hold = 1'b0;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned w;

  function automatic logic [31:0] rdata(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Bank model: answers every accepted request one cycle later, in order.
  initial begin
    logic   req_hs, rsp_hs;
    bresp_t r;
    bank_pvalid_i = 1'b0;
    bank_pdata_i  = '0;
    bank_pmeta_i  = '0;
    forever begin
      @(negedge clk_i);
      req_hs = rst_ni && bank_qvalid_o && bank_qready_i;
      rsp_hs = bank_pvalid_i && bank_pready_o;
      r      = '{data: rdata(bank_qaddr_o), meta: bank_qmeta_o};
      @(posedge clk_i); #1;
      if (rsp_hs && bank_rsp_q.size() > 0) void'(bank_rsp_q.pop_front());
      if (req_hs) bank_rsp_q.push_back(r);
      if (!rst_ni) bank_rsp_q.delete();
      if (bank_rsp_q.size() > 0 && !bank_hold) begin
        bank_pvalid_i = 1'b1;
        bank_pdata_i  = bank_rsp_q[0].data;
        bank_pmeta_i  = bank_rsp_q[0].meta;
      end else begin
        bank_pvalid_i = 1'b0;
      end
    end
  end

  // Monitor: pops the scoreboard whenever either output channel handshakes.
  initial begin
    breq_t  gb, eb;
    oresp_t go, eo;
    forever begin
      @(negedge clk_i);
      if (rst_ni && bank_qvalid_o && bank_qready_i) begin
        gb = {bank_qaddr_o, bank_qwrite_o, bank_qamo_o, bank_qdata_o, bank_qstrb_o, bank_qmeta_o};
        n_cmp++;
        if (exp_bank_q.size() == 0) begin
          n_bad++;
          $display("FAIL bank_req: got unexpected %h, expected none", gb);
        end else begin
          eb = exp_bank_q.pop_front();
          if (gb !== eb) begin
            n_bad++;
            $display("FAIL bank_req: got %h, expected %h", gb, eb);
          end
        end
      end
      if (rst_ni && out_pvalid_o && out_pready_i) begin
        go = {out_pdata_o, out_pmeta_o, out_plrwait_o};
        n_cmp++;
        if (out_plrwait_o ? (exp_su_q.size() == 0) : (exp_rsp_q.size() == 0)) begin
          n_bad++;
          $display("FAIL out_resp: got unexpected %h, expected none", go);
        end else begin
          eo = out_plrwait_o ? exp_su_q.pop_front() : exp_rsp_q.pop_front();
          if (go !== eo) begin
            n_bad++;
            $display("FAIL out_resp: got %h, expected %h", go, eo);
          end
        end
      end
    end
  end

  task automatic send(input string name, input logic [31:0] addr, input logic [3:0] amo,
                      input logic wr, input logic lrw, input logic [11:0] meta,
                      input logic [31:0] data, input int unsigned max_wait,
                      output int unsigned waited);
    in_qaddr_i = addr; in_qamo_i = amo; in_qwrite_i = wr; in_qlrwait_i = lrw;
    in_qmeta_i = meta; in_qdata_i = data; in_qstrb_i = 4'hF; in_qvalid_i = 1'b1;
    waited = 0;
    forever begin
      @(negedge clk_i);
      if (in_qready_o) break;
      waited++;
      if (waited >= max_wait) break;
      @(posedge clk_i); #1;
    end
    @(posedge clk_i); #1;
    in_qvalid_i = 1'b0;
    n_cmp++;
    if (waited >= max_wait) begin
      n_bad++;
      $display("FAIL %s: got no accept after %0d cycles, expected accept", name, waited);
    end
  endtask

  task automatic lr_fwd(input string name, input logic [31:0] a, input logic [11:0] m,
                        output int unsigned wt);
    exp_bank_q.push_back({a, 1'b0, LR, 32'h0, 4'hF, m});
    exp_rsp_q.push_back({rdata(a), m, 1'b0});
    send(name, a, LR, 1'b0, 1'b0, m, 32'h0, 20, wt);
  endtask

  task automatic sc_fwd(input string name, input logic [31:0] a, input logic [11:0] m);
    int unsigned wt;
    exp_bank_q.push_back({a, 1'b0, SC, SCDATA, 4'hF, m});
    exp_rsp_q.push_back({rdata(a), m, 1'b0});
    send(name, a, SC, 1'b0, 1'b0, m, SCDATA, 20, wt);
  endtask

  task automatic lr_succ(input string name, input logic [31:0] a, input logic [11:0] m,
                         input logic [11:0] prev);
    int unsigned wt;
    exp_su_q.push_back({20'h0, m, prev, 1'b1});
    send(name, a, LR, 1'b0, 1'b0, m, 32'h0, 20, wt);
  endtask

  task automatic probe_stall(input string name, input logic [31:0] a, input logic [11:0] m,
                             input int unsigned n);
    in_qaddr_i = a; in_qamo_i = LR; in_qwrite_i = 1'b0; in_qlrwait_i = 1'b0;
    in_qmeta_i = m; in_qdata_i = '0; in_qvalid_i = 1'b1;
    for (int unsigned i = 0; i < n; i++) begin
      @(negedge clk_i);
      check(name, {31'h0, in_qready_o}, 32'h0);
      @(posedge clk_i); #1;
    end
    in_qvalid_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk_i);
    #1 rst_ni = 1'b1;

    // Reset state
    @(negedge clk_i);
    check("rst_out_pvalid", {31'h0, out_pvalid_o}, 32'h0);
    check("rst_bank_pready", {31'h0, bank_pready_o}, 32'h1);
    check("rst_in_qready", {31'h0, in_qready_o}, 32'h1);
    @(posedge clk_i); #1;

    // Plain write passes through untouched
    exp_bank_q.push_back({32'h40, 1'b1, 4'h0, 32'h1234_5678, 4'hF, 12'h0AA});
    exp_rsp_q.push_back({rdata(32'h40), 12'h0AA, 1'b0});
    send("plain_wr", 32'h40, 4'h0, 1'b1, 1'b0, 12'h0AA, 32'h1234_5678, 20, w);

    // Single LR / SC; slot is free again on the very next request
    lr_fwd("lr1", 32'h100, 12'h011, w);
    sc_fwd("sc1", 32'h100, 12'h011);
    lr_fwd("lr1_reuse", 32'h100, 12'h022, w);
    check("lr1_reuse_wait", w, 32'd0);
    sc_fwd("sc1b", 32'h100, 12'h022);

    // Queue build-up, non-tail SC, WakeUp, tail SC
    lr_fwd("q_lr011", 32'h100, 12'h011, w);
    lr_succ("q_lr022_word", 32'h102, 12'h022, 12'h011);
    sc_fwd("q_sc011", 32'h100, 12'h011);
    lr_succ("q_lr033", 32'h100, 12'h033, 12'h022);
    exp_bank_q.push_back({32'h100, 1'b0, LR, 32'h0, 4'hF, 12'h022});
    exp_rsp_q.push_back({rdata(32'h100), 12'h022, 1'b0});
    send("q_wakeup", 32'h100, LR, 1'b0, 1'b1, 12'h011, 32'h0000_0022, 20, w);
    sc_fwd("q_sc022", 32'h100, 12'h022);
    sc_fwd("q_sc033", 32'h100, 12'h033);
    lr_fwd("q_lr044_new", 32'h100, 12'h044, w);
    sc_fwd("q_sc044", 32'h100, 12'h044);

    // All slots taken: fifth address stalls until an SC frees one
    lr_fwd("f_lr1", 32'h100, 12'h011, w);
    lr_fwd("f_lr2", 32'h200, 12'h021, w);
    lr_fwd("f_lr3", 32'h300, 12'h031, w);
    lr_fwd("f_lr4", 32'h400, 12'h041, w);
    probe_stall("f_lr5_stall", 32'h500, 12'h051, 3);
    sc_fwd("f_sc2", 32'h200, 12'h021);
    lr_fwd("f_lr5", 32'h500, 12'h051, w);
    check("f_lr5_wait", w, 32'd0);
    sc_fwd("f_sc1", 32'h100, 12'h011);
    sc_fwd("f_sc3", 32'h300, 12'h031);
    sc_fwd("f_sc4", 32'h400, 12'h041);
    sc_fwd("f_sc5", 32'h500, 12'h051);

    // SuccUpdate holds off the bank response and a further matching LR
    bank_hold = 1'b1;
    out_pready_i = 1'b0;
    lr_fwd("p_lr011", 32'h100, 12'h011, w);
    lr_succ("p_lr022", 32'h100, 12'h022, 12'h011);
    bank_hold = 1'b0;
    @(posedge clk_i); #1;
    @(negedge clk_i);
    check("p_out_plrwait", {31'h0, out_plrwait_o}, 32'h1);
    check("p_bank_pready", {31'h0, bank_pready_o}, 32'h0);
    exp_su_q.push_back({20'h0, 12'h033, 12'h022, 1'b1});
    @(posedge clk_i); #1;
    fork
      send("p_lr033", 32'h100, LR, 1'b0, 1'b0, 12'h033, 32'h0, 20, w);
      begin
        for (int unsigned i = 0; i < 3; i++) begin
          @(negedge clk_i);
          check("p_lr033_stall", {31'h0, in_qready_o}, 32'h0);
          check("p_bank_pready_hold", {31'h0, bank_pready_o}, 32'h0);
        end
        @(posedge clk_i); #1;
        out_pready_i = 1'b1;
      end
    join
    check("p_lr033_wait", w, 32'd3);
    repeat (4) @(posedge clk_i); #1;
    sc_fwd("p_sc033", 32'h100, 12'h033);

    // Reset mid-operation with two slots valid and a SuccUpdate pending
    lr_fwd("r_lrA", 32'h100, 12'h011, w);
    lr_fwd("r_lrB", 32'h200, 12'h044, w);
    repeat (5) @(posedge clk_i); #1;
    out_pready_i = 1'b0;
    send("r_lrA_succ", 32'h100, LR, 1'b0, 1'b0, 12'h055, 32'h0, 20, w);
    @(negedge clk_i);
    check("r_su_pending", {31'h0, out_pvalid_o}, 32'h1);
    @(posedge clk_i); #1;
    rst_ni = 1'b0;
    #1;
    check("r_out_pvalid_async", {31'h0, out_pvalid_o}, 32'h0);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    out_pready_i = 1'b1;
    @(posedge clk_i); #1;
    @(negedge clk_i);
    check("r_out_pvalid_after", {31'h0, out_pvalid_o}, 32'h0);
    @(posedge clk_i); #1;
    lr_fwd("r_lrA_new", 32'h100, 12'h066, w);
    lr_fwd("r_lrB_new", 32'h200, 12'h077, w);

    repeat (20) @(posedge clk_i);
    check("drain_bank_exp", exp_bank_q.size(), 32'd0);
    check("drain_su_exp", exp_su_q.size(), 32'd0);
    check("drain_rsp_exp", exp_rsp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
